// File: rtl/psum_drain_if.sv
// Row-in / word-out handshake bundle for psum_drain.
// The slave modport is the drain itself; master is its upstream core and downstream sink.
interface psum_drain_if #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int bw_out  = 16
);
  logic                       in_valid;
  logic [col*bw_psum-1:0]     in_row;
  logic                       in_ready;
  logic                       out_valid;
  logic [bw_out-1:0]          out_data;
  logic [$clog2(col)-1:0]     out_col;
  logic                       out_last;
  logic                       out_ready;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_data, out_col, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_data, out_col, out_last
  );
endinterface

// File: rtl/psum_drain.sv
// Row FIFO that serializes col-wide psum rows into one converted word per cycle.
// Define PSUM_DRAIN_SAT_EN for signed saturation; otherwise words are truncated.
module psum_drain #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int bw_out  = 16,
  parameter int depth   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  psum_drain_if.slave             bus,
  output logic [$clog2(depth):0]  rows_pending,
  output logic                    overflow,
  input  logic                    clr_ovf
);
  localparam int CIW = $clog2(col);
  localparam int PW  = $clog2(depth);
  localparam int CW  = PW + 1;

  localparam logic [CIW-1:0] LAST_COL = CIW'(col - 1);
  localparam logic [CW-1:0]  FULL     = CW'(depth);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [col*bw_psum-1:0] r_mem [depth];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [CIW-1:0]         r_col_idx;
  logic                   r_ovf;
  logic [0:0]             r_state;

  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_hs;
  logic                   w_pop;
  logic [CW-1:0]          w_count_next;
  logic [col*bw_psum-1:0] w_head;
  logic signed [bw_psum-1:0] w_cols [col];
  logic signed [bw_psum-1:0] w_psum;
  logic [bw_out-1:0]      w_conv;

  // Full-check uses only the stored count so in_ready never depends on out_ready.
  assign w_in_ready  = (r_count != FULL);
  assign w_out_valid = (r_state == ST_STREAM);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_drop      = bus.in_valid & ~w_in_ready;
  assign w_hs        = w_out_valid & bus.out_ready;
  assign w_pop       = w_hs & (r_col_idx == LAST_COL);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_row;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_col_idx <= '0;
      r_ovf     <= 1'b0;
      r_state   <= ST_EMPTY;
    end else begin
      r_count <= w_count_next;
      r_state <= (w_count_next != '0) ? ST_STREAM : ST_EMPTY;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_hs) begin
        r_col_idx <= r_col_idx + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  for (genvar k = 0; k < col; k++) begin : g_cols
    assign w_cols[k] = w_head[k*bw_psum +: bw_psum];
  end

  assign w_psum = w_cols[r_col_idx];

`ifdef PSUM_DRAIN_SAT_EN
  localparam logic signed [bw_psum-1:0] SAT_MAX =
    {{(bw_psum-bw_out+1){1'b0}}, {(bw_out-1){1'b1}}};
  localparam logic signed [bw_psum-1:0] SAT_MIN =
    {{(bw_psum-bw_out+1){1'b1}}, {(bw_out-1){1'b0}}};

  always_comb begin
    w_conv = w_psum[bw_out-1:0];
    if (w_psum > SAT_MAX) begin
      w_conv = SAT_MAX[bw_out-1:0];
    end else if (w_psum < SAT_MIN) begin
      w_conv = SAT_MIN[bw_out-1:0];
    end
  end
`else
  assign w_conv = w_psum[bw_out-1:0];

  if (bw_psum > bw_out) begin : g_trunc
    logic w_unused_hi;
    assign w_unused_hi = ^w_psum[bw_psum-1:bw_out];
  end
`endif

  // Word outputs are forced to zero when idle so stale FIFO contents never leak out.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_conv : '0;
  assign bus.out_col   = r_col_idx;
  assign bus.out_last  = w_out_valid & (r_col_idx == LAST_COL);
  assign rows_pending  = r_count;
  assign overflow      = r_ovf;
endmodule

// File: tb/tb_psum_drain.sv
// Randomized self-checking bench for psum_drain against a row-queue reference model.
// Honors PSUM_DRAIN_SAT_EN in the same way as the design.
module tb_psum_drain;
  localparam int COL   = 8;
  localparam int BWP   = 20;
  localparam int BWO   = 16;
  localparam int DEPTH = 4;
  localparam int ROWW  = COL * BWP;

  logic clk;
  logic reset;
  logic clrOvf;
  logic [$clog2(DEPTH):0] rowsPending;
  logic overflow;

  psum_drain_if #(.col(COL), .bw_psum(BWP), .bw_out(BWO)) busIf ();

  psum_drain #(.col(COL), .bw_psum(BWP), .bw_out(BWO), .depth(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (busIf),
    .rows_pending (rowsPending),
    .overflow     (overflow),
    .clr_ovf      (clrOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  logic [ROWW-1:0] rowQ[$];
  int  colPos = 0;
  logic modelOvf = 1'b0;

  function automatic logic [BWO-1:0] refConv(input logic [BWP-1:0] p);
    int v;
    v = int'(signed'(p));
`ifdef PSUM_DRAIN_SAT_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return BWO'(v & 32'hFFFF);
  endfunction

  function automatic logic [ROWW-1:0] randRow();
    logic [ROWW-1:0] r;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      if ($urandom_range(0, 1) == 1)
        r[k*BWP +: BWP] = BWP'(int'($urandom_range(0, 2000)) - 1000);
      else
        r[k*BWP +: BWP] = BWP'($urandom);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkState();
    logic expValid;
    logic [BWO-1:0] expData;
    expValid = (rowQ.size() > 0);
    expData  = expValid ? refConv(rowQ[0][colPos*BWP +: BWP]) : '0;
    checkOutput("out_valid", 32'(busIf.out_valid), 32'(expValid));
    checkOutput("out_data", 32'(busIf.out_data), 32'(expData));
    checkOutput("out_col", 32'(busIf.out_col), 32'(colPos));
    checkOutput("out_last", 32'(busIf.out_last), 32'(expValid && colPos == COL - 1));
    checkOutput("in_ready", 32'(busIf.in_ready), 32'(rowQ.size() < DEPTH));
    checkOutput("rows_pending", 32'(rowsPending), 32'(rowQ.size()));
    checkOutput("overflow", 32'(overflow), 32'(modelOvf));
  endtask

  // One clock: check at the falling edge, drive inputs, then advance the model at the rising edge.
  task automatic applyStimulus(input logic inV, input logic [ROWW-1:0] row,
                               input logic outR, input logic clr);
    bit canPush;
    bit hs;
    bit pop;
    @(negedge clk);
    checkState();
    busIf.in_valid  = inV;
    busIf.in_row    = row;
    busIf.out_ready = outR;
    clrOvf          = clr;
    @(posedge clk);
    canPush = (rowQ.size() < DEPTH);
    hs      = (rowQ.size() > 0) && outR;
    pop     = hs && (colPos == COL - 1);
    if (hs) colPos = (colPos + 1) % COL;
    if (pop) void'(rowQ.pop_front());
    if (inV && canPush) rowQ.push_back(row);
    if (inV && !canPush) modelOvf = 1'b1;
    else if (clr) modelOvf = 1'b0;
  endtask

  task automatic enterReset();
    reset           = 1'b0;
    busIf.in_valid  = 1'b0;
    busIf.out_ready = 1'b0;
    clrOvf          = 1'b0;
    rowQ.delete();
    colPos   = 0;
    modelOvf = 1'b0;
    #1;
    checkState();
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkState();
    reset = 1'b1;
  endtask

  task automatic idle(input int n, input logic outR);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, outR, 1'b0);
  endtask

  logic [ROWW-1:0] row;

  initial begin
    busIf.in_valid  = 1'b0;
    busIf.in_row    = '0;
    busIf.out_ready = 1'b0;
    clrOvf          = 1'b0;
    reset           = 1'b1;
    #2;
    enterReset();
    releaseReset();

    // Single row 1..8 with the sink always ready.
    row = '0;
    for (int k = 0; k < COL; k++) row[k*BWP +: BWP] = BWP'(k + 1);
    applyStimulus(1'b1, row, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Five rows into a stalled sink: fifth is dropped, then overflow is cleared.
    for (int r = 0; r < 5; r++) applyStimulus(1'b1, randRow(), 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(34, 1'b1);

    // Conversion boundaries.
    row = '0;
    row[0*BWP +: BWP] = BWP'(40000);
    row[1*BWP +: BWP] = BWP'(-40000);
    row[2*BWP +: BWP] = BWP'(-5);
    row[3*BWP +: BWP] = BWP'(32767);
    row[4*BWP +: BWP] = BWP'(-32768);
    row[5*BWP +: BWP] = BWP'(32768);
    row[6*BWP +: BWP] = BWP'(-32769);
    applyStimulus(1'b1, row, 1'b1, 1'b0);
    idle(9, 1'b1);

    // Sink ready toggling 1-0-1-0 across a row.
    applyStimulus(1'b1, randRow(), 1'b0, 1'b0);
    for (int i = 0; i < 2 * COL + 2; i++) applyStimulus(1'b0, '0, (i % 2) == 0, 1'b0);

    // Full FIFO with in_valid held while the head row finishes, then wrap over many rows.
    for (int r = 0; r < DEPTH; r++) applyStimulus(1'b1, randRow(), 1'b0, 1'b0);
    for (int i = 0; i < 3 * COL; i++) applyStimulus(1'b1, randRow(), 1'b1, 1'b0);
    for (int i = 0; i < 12 * COL; i++)
      applyStimulus($urandom_range(0, 3) == 0, randRow(), $urandom_range(0, 4) != 0, 1'b0);
    idle(5 * COL, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Reset asserted after column 3 with two rows pending.
    applyStimulus(1'b1, randRow(), 1'b1, 1'b0);
    applyStimulus(1'b1, randRow(), 1'b1, 1'b0);
    idle(3, 1'b1);
    #2;
    enterReset();
    releaseReset();
    applyStimulus(1'b1, randRow(), 1'b1, 1'b0);
    idle(COL + 1, 1'b1);

    // Free-running random traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 2) != 0, randRow(),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    idle(5 * COL, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
